// File: rtl/sync_trigger_pkg.sv
// Shared definitions for the external trigger synchroniser: edge-mode codes,
// the channel FSM state type and the edge qualification helper.
package sync_trigger_pkg;

   localparam logic [1:0] EDGE_OFF  = 2'b00;
   localparam logic [1:0] EDGE_RISE = 2'b01;
   localparam logic [1:0] EDGE_FALL = 2'b10;
   localparam logic [1:0] EDGE_BOTH = 2'b11;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_HOLDOFF = 1'b1
   } ch_state_t;

   function automatic logic edge_qualified(input logic [1:0] mode,
                                           input logic       rise,
                                           input logic       fall);
      return (rise && (mode == EDGE_RISE || mode == EDGE_BOTH)) ||
             (fall && (mode == EDGE_FALL || mode == EDGE_BOTH));
   endfunction

endpackage

// File: rtl/sync_trigger_channel.sv
// One trigger channel: synchroniser, glitch filter, edge qualification,
// hold-off FSM, event counter and sticky dropped-edge flag.
module sync_trigger_channel
   import sync_trigger_pkg::*;
#(
   parameter int SYNC_STAGES = 3,
   parameter int CNT_W       = 16,
   parameter int EVT_W       = 16
) (
   input  logic             clk,
   input  logic             srst,
   input  logic             trig_in,
   input  logic             enable,
   input  logic [1:0]       mode,
   input  logic [CNT_W-1:0] glitch_cycles,
   input  logic [CNT_W-1:0] holdoff_cycles,
   input  logic             count_clear,
   output logic             level,
   output logic             pulse,
   output logic [EVT_W-1:0] event_count,
   output logic             dropped
);

   logic [SYNC_STAGES-1:0] sync_reg;
   logic                   sample;

   logic                   level_reg, level_next;
   logic                   prev_level_reg;
   logic [CNT_W-1:0]       glitch_cnt_reg, glitch_cnt_next;

   ch_state_t              state_reg, state_next;
   logic [CNT_W-1:0]       hold_cnt_reg, hold_cnt_next;
   logic                   pulse_reg, pulse_next;
   logic [EVT_W-1:0]       count_reg, count_next;
   logic                   dropped_reg, dropped_next;

   logic                   rise;
   logic                   fall;
   logic                   qualified;

   assign sample = sync_reg[SYNC_STAGES-1];

   // Glitch filter: a disagreeing sample must persist for glitch_cycles+1
   // cycles; >= keeps the filter from stalling if the setting is lowered.
   always_comb begin
      level_next      = level_reg;
      glitch_cnt_next = '0;
      if (sample != level_reg) begin
         if (glitch_cnt_reg >= glitch_cycles) begin
            level_next = sample;
         end else begin
            glitch_cnt_next = glitch_cnt_reg + CNT_W'(1);
         end
      end
   end

   assign rise      = level_reg & ~prev_level_reg;
   assign fall      = ~level_reg & prev_level_reg;
   assign qualified = edge_qualified(mode, rise, fall);

   always_comb begin
      state_next    = state_reg;
      hold_cnt_next = hold_cnt_reg;
      pulse_next    = 1'b0;
      count_next    = count_reg;
      dropped_next  = dropped_reg;

      if (!enable) begin
         state_next    = ST_IDLE;
         hold_cnt_next = '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (qualified) begin
                  pulse_next = 1'b1;
                  count_next = count_reg + EVT_W'(1);
                  if (holdoff_cycles != '0) begin
                     state_next    = ST_HOLDOFF;
                     hold_cnt_next = holdoff_cycles;
                  end
               end
            end
            ST_HOLDOFF: begin
               if (qualified) begin
                  dropped_next = 1'b1;
               end
               // Leave hold-off on the same edge the counter hits zero.
               if (hold_cnt_reg <= CNT_W'(1)) begin
                  state_next    = ST_IDLE;
                  hold_cnt_next = '0;
               end else begin
                  hold_cnt_next = hold_cnt_reg - CNT_W'(1);
               end
            end
            default: begin
               state_next    = ST_IDLE;
               hold_cnt_next = '0;
            end
         endcase
      end

      if (count_clear) begin
         count_next   = '0;
         dropped_next = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         sync_reg       <= '0;
         level_reg      <= 1'b0;
         prev_level_reg <= 1'b0;
         glitch_cnt_reg <= '0;
         state_reg      <= ST_IDLE;
         hold_cnt_reg   <= '0;
         pulse_reg      <= 1'b0;
         count_reg      <= '0;
         dropped_reg    <= 1'b0;
      end else begin
         sync_reg       <= {sync_reg[SYNC_STAGES-2:0], trig_in};
         level_reg      <= level_next;
         prev_level_reg <= level_reg;
         glitch_cnt_reg <= glitch_cnt_next;
         state_reg      <= state_next;
         hold_cnt_reg   <= hold_cnt_next;
         pulse_reg      <= pulse_next;
         count_reg      <= count_next;
         dropped_reg    <= dropped_next;
      end
   end

   assign level       = level_reg;
   assign pulse       = pulse_reg;
   assign event_count = count_reg;
   assign dropped     = dropped_reg;

endmodule

// File: rtl/sync_external_trigger.sv
// Multi-channel external trigger synchroniser: N_CH independent channels
// plus a registered OR of all channel pulses.
module sync_external_trigger
   import sync_trigger_pkg::*;
#(
   parameter int N_CH        = 4,
   parameter int SYNC_STAGES = 3,
   parameter int CNT_W       = 16,
   parameter int EVT_W       = 16
) (
   input  logic                  aclk,
   input  logic                  areset,
   input  logic [N_CH-1:0]       external_input,
   input  logic [N_CH-1:0]       ch_enable,
   input  logic [2*N_CH-1:0]     edge_mode,
   input  logic [CNT_W-1:0]      glitch_cycles,
   input  logic [CNT_W-1:0]      holdoff_cycles,
   input  logic                  count_clear,
   output logic [N_CH-1:0]       level_filtered,
   output logic [N_CH-1:0]       pulse_detected,
   output logic                  pulse_any,
   output logic [N_CH*EVT_W-1:0] event_count,
   output logic [N_CH-1:0]       dropped
);

   logic pulse_any_reg;

   generate
      for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
         sync_trigger_channel #(
            .SYNC_STAGES (SYNC_STAGES),
            .CNT_W       (CNT_W),
            .EVT_W       (EVT_W)
         ) u_ch (
            .clk            (aclk),
            .srst           (areset),
            .trig_in        (external_input[gi]),
            .enable         (ch_enable[gi]),
            .mode           (edge_mode[2*gi+1:2*gi]),
            .glitch_cycles  (glitch_cycles),
            .holdoff_cycles (holdoff_cycles),
            .count_clear    (count_clear),
            .level          (level_filtered[gi]),
            .pulse          (pulse_detected[gi]),
            .event_count    (event_count[EVT_W*gi +: EVT_W]),
            .dropped        (dropped[gi])
         );
      end
   endgenerate

   always_ff @(posedge aclk) begin
      if (areset) begin
         pulse_any_reg <= 1'b0;
      end else begin
         pulse_any_reg <= |pulse_detected;
      end
   end

   assign pulse_any = pulse_any_reg;

endmodule

// File: doc/sync_external_trigger.md
Name: sync_external_trigger

Overview:
- Multi-channel successor to the single-input external pulse synchroniser. Brings N_CH asynchronous external trigger lines into the aclk domain.
- Per channel: a glitch filter of programmable length, selectable edge qualification, and a programmable hold-off window, producing one-cycle pulses.
- Also provides per-channel event counters.
- Sits between the board trigger inputs and the scope acquisition/sequencer logic.

Parameters:
- N_CH, 4, number of independent trigger channels (1..16).
- SYNC_STAGES, 3, synchroniser flop depth per channel (2..8).
- CNT_W, 16, width of glitch and hold-off counters and their runtime settings.
- EVT_W, 16, width of each per-channel event counter.

Ports:
- aclk  in  1  sole clock.
- areset  in  1  reset. One clock; reset is synchronous and active-high.
- external_input  in  N_CH  asynchronous trigger lines; bit i = channel i.
- ch_enable  in  N_CH  per-channel pulse enable.
- edge_mode  in  2*N_CH  bits [2i+1:2i] for channel i: 00 off, 01 rising, 10 falling, 11 both.
- glitch_cycles  in  CNT_W  shared filter length: the level must be stable for glitch_cycles+1 cycles.
- holdoff_cycles  in  CNT_W  shared dead time after each accepted pulse.
- count_clear  in  1  synchronous clear of all event counters.
- level_filtered  out  N_CH  debounced level per channel.
- pulse_detected  out  N_CH  one-cycle pulse per accepted event.
- pulse_any  out  1  OR of pulse_detected, registered (one cycle later).
- event_count  out  N_CH*EVT_W  accepted-event count; channel i at [EVT_W*(i+1)-1 : EVT_W*i].
- dropped  out  N_CH  sticky flag: a qualified edge arrived during hold-off; cleared by count_clear.

Behaviour:
- Reset: areset high at a rising aclk edge forces the following to 0 on that edge:
  - synchroniser flops, filter counters, level_filtered;
  - pulse_detected, pulse_any, event_count, dropped;
  - hold-off counters, and all channel FSMs to IDLE.
- Reset mid-operation aborts any hold-off. Pulses in flight are lost.
- A line held high through reset is filtered to 1 after release and produces a rising-edge event if enabled.
- Synchroniser: SYNC_STAGES-deep shift of external_input[i]. Only the last stage is used downstream.
- Glitch filter:
  - While the synced sample equals level_filtered, the counter is held at 0.
  - While it differs, the counter increments.
  - When the counter reaches glitch_cycles, level_filtered takes the sample and the counter returns to 0.
  - Any return to agreement before then resets the counter to 0; the glitch is ignored.
  - glitch_cycles = 0 means level_filtered follows the sample with one cycle delay.
- Edge qualification:
  - rise = level_filtered 0->1; fall = 1->0, both registered against the previous filtered value.
  - Qualified edge = (rise AND edge_mode[0]) OR (fall AND edge_mode[1]).
- Channel FSM states: IDLE, HOLDOFF.
  - IDLE, qualified edge, ch_enable=1: assert pulse_detected[i] next cycle for exactly 1 cycle and increment event_count.
    - holdoff_cycles = 0: stay in IDLE, so back-to-back edges are all accepted.
    - Otherwise: load the hold-off counter with holdoff_cycles and enter HOLDOFF.
  - HOLDOFF: decrement each cycle; enter IDLE on the cycle the counter reaches 0. Total dead time = holdoff_cycles cycles after the pulse.
  - Qualified edge in HOLDOFF: no pulse, no count, set dropped[i].
- ch_enable=0: filter keeps tracking; FSM forced to IDLE; no pulse; no count; dropped not set.
- Latency: from the first aclk edge that samples a new input level to pulse_detected high is SYNC_STAGES + glitch_cycles + 2 edges. pulse_any follows one edge later.
- Counter arithmetic:
  - event_count wraps modulo 2^EVT_W.
  - count_clear has priority over a simultaneous increment; the result is 0 and the event is not counted.
  - count_clear does not affect the FSM or the filter.
- Runtime settings: edge_mode, glitch_cycles and holdoff_cycles are sampled every cycle. A change takes effect on the next comparison or load; a counter already loaded is not reloaded.

Decomposition:
- Package sync_trigger_pkg holds:
  - edge-mode constants EDGE_OFF=2'b00, EDGE_RISE=2'b01, EDGE_FALL=2'b10, EDGE_BOTH=2'b11;
  - FSM state encoding ST_IDLE, ST_HOLDOFF.
- Sub-module sync_trigger_channel implements one channel: synchroniser, filter, edge detection, FSM, counter, dropped flag.
- The top module generates N_CH instances and builds pulse_any.

Test Plan:
- Basic rise: SYNC_STAGES=3, glitch=2, holdoff=0, mode=01. Raise input[0] and hold.
  -> pulse_detected[0] high exactly 1 cycle, 7 edges after the first sampling edge.
  -> pulse_any one cycle later; event_count[0]=1.
- Glitch reject: glitch=4. A 3-cycle high blip (on the synced side) -> level_filtered stays 0, no pulse, count 0. A 5-cycle high -> level_filtered=1, one pulse.
- Hold-off: holdoff=10, mode=11. Edges at filtered cycles 0, 4, 12.
  -> pulses for the edges at 0 and 12 only; dropped[0]=1; count=2.
- Wrap and clear: EVT_W=4, 16 accepted edges -> count wraps to 0. count_clear asserted on the same cycle as the 17th pulse -> count=0 and dropped cleared.
- Enable and mode: ch_enable[1]=0 with toggling input -> no pulses, level_filtered[1] tracks. Set mode=10 and enable -> pulses on falls only.
- Reset mid-holdoff: areset during HOLDOFF with input held high -> all outputs 0. After release, one rising-edge pulse, count=1.
